ides_n_train: RTL

Parametrised DDR input deserializer for the DDR3 PHY read path and the gw2a simulation library. It captures LANES serial inputs on both edges of CLK and assembles RATIO-bit words. Each lane has its own bit-slip alignment, manual or automatic (training against a fixed pattern). It generalises the fixed 4:1 single-lane deserializer to N:1, multi-lane, with lock and error reporting.

---
 rtl/ides_n_train_if.sv | 19 +
 rtl/ides_n_train.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ides_n_train_if.sv
// Parallel-side bundle of the N:1 DDR deserializer: serial lanes, slip and
// training controls in, assembled words and per-lane training status out.
interface ides_n_train_if #(
  parameter int RATIO = 4,
  parameter int LANES = 1,
  parameter int OW    = $clog2(RATIO)
);
  logic [LANES-1:0]       D;
  logic [LANES-1:0]       CALIB;
  logic                   TRAIN;
  logic [LANES*RATIO-1:0] Q;
  logic                   VALID;
  logic [LANES-1:0]       LOCKED;
  logic [LANES-1:0]       ERR;
  logic [LANES*OW-1:0]    OFFSET;

  modport master (output D, CALIB, TRAIN, input Q, VALID, LOCKED, ERR, OFFSET);
  modport slave  (input D, CALIB, TRAIN, output Q, VALID, LOCKED, ERR, OFFSET);
endinterface

// File: rtl/ides_n_train.sv
// DDR input deserializer, RATIO:1 over LANES lanes, with per-lane bit slip
// (manual via CALIB or automatic training against PATTERN).
module ides_n_train #(
  parameter int               RATIO     = 4,
  parameter int               LANES     = 1,
  parameter logic [RATIO-1:0] PATTERN   = 4'b0011,
  parameter int               MATCH_CNT = 4,
  parameter int               SETTLE    = 2,
  parameter int               OW        = $clog2(RATIO)
) (
  input  logic          CLK,
  input  logic          RESETN,
  ides_n_train_if.slave bus
);

  localparam int HALF = RATIO / 2;
  localparam int WW   = (RATIO > 2) ? $clog2(HALF) : 1;
  localparam int SW   = $clog2(2 * RATIO + 1);
  localparam int HW   = 2 * RATIO - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SLIP_WAIT,
    S_LOCKED,
    S_FAIL
  } state_t;

  logic [LANES-1:0] r_smp;
  logic [LANES-1:0] f_smp;
  logic [LANES-1:0] calib_q;
  logic             train_q;
  logic [WW-1:0]    wcnt;
  logic             valid_r;
  logic             word_end;
  logic             train_rise;
  logic [LANES-1:0] calib_rise;
  logic [LANES-1:0] lock_r;
  logic [LANES-1:0] err_r;

  // The oldest bit of the 2*RATIO history can never fall inside a window,
  // so only the upper 2*RATIO-1 bits are stored (index shifted down by one).
  logic [HW-1:0]    hist [LANES];
  logic [RATIO-1:0] win  [LANES];
  logic [RATIO-1:0] q_r  [LANES];
  logic [OW-1:0]    offs [LANES];
  state_t           st   [LANES];
  logic [3:0]       mcnt [LANES];
  logic [SW-1:0]    scnt [LANES];
  logic [1:0]       tcnt [LANES];

  function automatic logic [OW-1:0] next_off(input logic [OW-1:0] o);
    return (o == OW'(RATIO - 1)) ? '0 : o + 1'b1;
  endfunction

  assign word_end   = (wcnt == WW'(HALF - 1));
  assign train_rise = bus.TRAIN & ~train_q;
  assign calib_rise = bus.CALIB & ~calib_q;

  always_comb begin
    bus.Q      = '0;
    bus.OFFSET = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      win[i]                       = hist[i][(RATIO - 1 - int'(offs[i])) +: RATIO];
      bus.Q[i*RATIO +: RATIO]      = q_r[i];
      bus.OFFSET[i*OW +: OW]       = offs[i];
    end
  end

  assign bus.VALID  = valid_r;
  assign bus.LOCKED = lock_r;
  assign bus.ERR    = err_r;

  always_ff @(negedge CLK or negedge RESETN) begin
    if (!RESETN) f_smp <= '0;
    else         f_smp <= bus.D;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wcnt    <= '0;
      valid_r <= 1'b0;
      r_smp   <= '0;
      calib_q <= '0;
      // Preset high so a TRAIN level held through reset is not taken as an edge.
      train_q <= 1'b1;
      lock_r  <= '0;
      err_r   <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        hist[i] <= '0;
        q_r[i]  <= '0;
        offs[i] <= '0;
        st[i]   <= S_IDLE;
        mcnt[i] <= '0;
        scnt[i] <= '0;
        tcnt[i] <= '0;
      end
    end else begin
      r_smp   <= bus.D;
      calib_q <= bus.CALIB;
      train_q <= bus.TRAIN;
      wcnt    <= word_end ? '0 : wcnt + 1'b1;
      valid_r <= word_end;
      for (int unsigned i = 0; i < LANES; i++) begin
        hist[i] <= {f_smp[i], r_smp[i], hist[i][HW-1:2]};
        if (word_end) q_r[i] <= win[i];
        if (!bus.TRAIN) begin
          st[i] <= S_IDLE;
          if (calib_rise[i]) offs[i] <= next_off(offs[i]);
        end else begin
          case (st[i])
            S_IDLE: begin
              if (train_rise) begin
                lock_r[i] <= 1'b0;
                err_r[i]  <= 1'b0;
                mcnt[i]   <= '0;
                scnt[i]   <= '0;
                tcnt[i]   <= '0;
                st[i]     <= S_CHECK;
              end
            end
            S_CHECK: begin
              if (word_end) begin
                if (win[i] == PATTERN) begin
                  mcnt[i] <= mcnt[i] + 1'b1;
                  if (mcnt[i] == 4'(MATCH_CNT - 1)) begin
                    lock_r[i] <= 1'b1;
                    st[i]     <= S_LOCKED;
                  end
                end else begin
                  mcnt[i] <= '0;
                  if (scnt[i] == SW'(2 * RATIO)) begin
                    err_r[i] <= 1'b1;
                    st[i]    <= S_FAIL;
                  end else begin
                    offs[i] <= next_off(offs[i]);
                    scnt[i] <= scnt[i] + 1'b1;
                    tcnt[i] <= '0;
                    st[i]   <= S_SLIP_WAIT;
                  end
                end
              end
            end
            S_SLIP_WAIT: begin
              if (word_end) begin
                if (tcnt[i] == 2'(SETTLE - 1)) st[i] <= S_CHECK;
                else                           tcnt[i] <= tcnt[i] + 1'b1;
              end
            end
            default: st[i] <= st[i];
          endcase
        end
      end
    end
  end

endmodule
